rr_mult_sel: RTL and testbench



---
 rtl/rr_mult_sel_pkg.sv | 30 +++
 rtl/rr_mult_sel_vec2int.sv | 32 +++
 rtl/rr_mult_sel.sv | 193 +++++++++++++++++++
 tb/tb_rr_mult_sel.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mult_sel_pkg.sv
// rr_mult_sel_pkg: shared helpers for the radix-R online multiplier selection stage.
// Digit width, radix legality, residual sizing and FSM state encoding.
package rr_mult_sel_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWarm  = 2'd1,
      StRun   = 2'd2,
      StFlush = 2'd3
   } state_e;

   // Signed digit width: enough for [-R, R-1].
   function automatic int unsigned digit_width(input int unsigned radix);
      return $clog2(radix) + 1;
   endfunction

   function automatic bit radix_ok(input int unsigned radix);
      return (radix == 2) || (radix == 4) || (radix == 8) || (radix == 16);
   endfunction

   // log2(U) where U = R^(P-1).
   function automatic int unsigned u_shift(input int unsigned radix, input int unsigned p);
      return $clog2(radix) * (p - 1);
   endfunction

   function automatic int unsigned resid_width(input int unsigned radix, input int unsigned p);
      return digit_width(radix) * p + digit_width(radix) + 2;
   endfunction

endpackage

// File: rtl/rr_mult_sel_vec2int.sv
// rr_mult_sel_vec2int: weights a P-digit signed radix-R vector into a WW-bit
// two's-complement integer (digit 0 least significant). Purely combinational.
module rr_mult_sel_vec2int
   import rr_mult_sel_pkg::*;
#(
   parameter int unsigned RADIX = 4,
   parameter int unsigned P     = 3,
   parameter int unsigned WW    = 14
) (
   input  logic [digit_width(RADIX)*P-1:0] pp,
   output logic signed [WW-1:0]            ppv
);

   localparam int unsigned D  = digit_width(RADIX);
   localparam int unsigned LR = $clog2(RADIX);

   logic signed [D-1:0]  dig;
   logic signed [WW-1:0] ext;

   // Sign-extend each digit and accumulate it at weight R^i.
   always_comb begin
      ppv = '0;
      dig = '0;
      ext = '0;
      for (int i = 0; i < int'(P); i++) begin
         dig = pp[D*i +: D];
         ext = {{(WW-D){dig[D-1]}}, dig};
         ppv = ppv + (ext <<< (LR * i));
      end
   end

endmodule

// File: rtl/rr_mult_sel.sv
// rr_mult_sel: residual update, digit selection and output handshake of the MSDF
// online multiplier. Optional build macro RR_MULT_SEL_SAT_FLAG_EN adds a sticky
// sat_err output that flags clamped digit selections.
module rr_mult_sel
   import rr_mult_sel_pkg::*;
#(
   parameter int unsigned RADIX = 4,
   parameter int unsigned P     = 3,
   parameter int unsigned DELTA = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [digit_width(RADIX)*P-1:0] pp,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic [digit_width(RADIX)-1:0] z,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy
`ifdef RR_MULT_SEL_SAT_FLAG_EN
   ,
   output logic                          sat_err
`endif
);

   localparam int unsigned D  = digit_width(RADIX);
   localparam int unsigned LR = $clog2(RADIX);
   localparam int unsigned SH = u_shift(RADIX, P);
   localparam int unsigned WW = resid_width(RADIX, P);

   // Selection arithmetic uses one guard bit so the rounding offset never wraps.
   localparam logic signed [WW:0] HALF    = (WW+1)'(2 ** (SH - 1));
   localparam logic signed [WW:0] ZMAX    = (WW+1)'(RADIX - 1);
   localparam logic signed [WW:0] ZMIN    = -ZMAX;
   localparam logic [15:0]        DELTA_C = 16'(DELTA);

   if (!radix_ok(RADIX) || (P < 2) || (DELTA < 1) || (DELTA > 7)) begin : g_bad_param
      $error("rr_mult_sel: unsupported RADIX/P/DELTA");
   end

   state_e               state_q;
   logic signed [WW-1:0] w_q;
   logic [D-1:0]         z_q;
   logic                 out_valid_q;
   logic [15:0]          acc_q, emitted_q, wcnt_q;

   logic signed [WW-1:0] ppv, ppv_eff, v, z_ext, w_sel;
   logic signed [WW:0]   rnd, zr_full;
   logic signed [D-1:0]  z_sel;
   logic                 hi, lo;
   logic                 slot_free, ready_st, accept;

   rr_mult_sel_vec2int #(
      .RADIX (RADIX),
      .P     (P),
      .WW    (WW)
   ) u_vec2int (
      .pp  (pp),
      .ppv (ppv)
   );

   // Scale the residual, add this cycle's partial product (none while draining),
   // round to the nearest digit, clamp, and form the reduced residual.
   always_comb begin
      ppv_eff = (state_q == StFlush) ? '0 : ppv;
      v       = (w_q <<< LR) + ppv_eff;
      rnd     = {v[WW-1], v} + HALF;
      zr_full = rnd >>> SH;
      hi      = zr_full > ZMAX;
      lo      = zr_full < ZMIN;
      if (hi) begin
         z_sel = ZMAX[D-1:0];
      end else if (lo) begin
         z_sel = ZMIN[D-1:0];
      end else begin
         z_sel = zr_full[D-1:0];
      end
      z_ext = {{(WW-D){z_sel[D-1]}}, z_sel};
      w_sel = v - (z_ext <<< SH);
   end

   // Input readiness per state; RUN only accepts when the output slot can take a digit.
   always_comb begin
      ready_st = 1'b0;
      unique case (state_q)
         StIdle, StWarm: ready_st = 1'b1;
         StRun:          ready_st = slot_free;
         StFlush:        ready_st = 1'b0;
      endcase
   end

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = ready_st && !rst;
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q != StIdle);
   assign z         = z_q;
   assign out_valid = out_valid_q;

`ifdef RR_MULT_SEL_SAT_FLAG_EN
   logic sat_q;
   assign sat_err = sat_q;
`endif

   // Operation FSM: warm-up accumulation, digit emission, drain, return to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         w_q         <= '0;
         z_q         <= '0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         emitted_q   <= '0;
         wcnt_q      <= '0;
`ifdef RR_MULT_SEL_SAT_FLAG_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  w_q       <= v;
                  acc_q     <= 16'd1;
                  wcnt_q    <= 16'd1;
                  emitted_q <= '0;
                  if (in_last) begin
                     state_q <= StFlush;
                  end else begin
`ifdef RR_MULT_SEL_SAT_FLAG_EN
                     sat_q <= 1'b0;
`endif
                     if (DELTA == 1) begin
                        state_q <= StRun;
                     end else begin
                        state_q <= StWarm;
                     end
                  end
               end
            end
            StWarm: begin
               if (accept) begin
                  w_q    <= v;
                  acc_q  <= acc_q + 16'd1;
                  wcnt_q <= wcnt_q + 16'd1;
                  if (in_last) begin
                     state_q <= StFlush;
                  end else if (wcnt_q + 16'd1 == DELTA_C) begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (accept) begin
                  w_q         <= w_sel;
                  z_q         <= z_sel;
                  out_valid_q <= 1'b1;
                  acc_q       <= acc_q + 16'd1;
                  emitted_q   <= emitted_q + 16'd1;
`ifdef RR_MULT_SEL_SAT_FLAG_EN
                  if (hi || lo) sat_q <= 1'b1;
`endif
                  if (in_last) begin
                     state_q <= StFlush;
                  end
               end
            end
            StFlush: begin
               if (slot_free) begin
                  if (emitted_q != acc_q) begin
                     w_q         <= w_sel;
                     z_q         <= z_sel;
                     out_valid_q <= 1'b1;
                     emitted_q   <= emitted_q + 16'd1;
`ifdef RR_MULT_SEL_SAT_FLAG_EN
                     if (hi || lo) sat_q <= 1'b1;
`endif
                  end else begin
                     state_q   <= StIdle;
                     w_q       <= '0;
                     acc_q     <= '0;
                     emitted_q <= '0;
                     wcnt_q    <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mult_sel.sv
// tb_rr_mult_sel: randomized and directed checks of rr_mult_sel (RADIX=4, P=3, DELTA=2)
// against an integer reference model of the residual/selection recurrence.
module tb_rr_mult_sel;

   localparam int RADIX = 4;
   localparam int P     = 3;
   localparam int DLT   = 2;
   localparam int D     = 3;
   localparam int PW    = D * P;
   localparam int U     = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] pp;
   logic          in_valid, in_last, in_ready;
   logic [D-1:0]  z;
   logic          out_valid, out_ready, busy;
`ifdef RR_MULT_SEL_SAT_FLAG_EN
   logic          sat_err;
`endif

   int            n_checks = 0;
   int            n_errors = 0;
   logic [PW-1:0] op_pp[$];
   int            exp_q[$];
   bit            exp_sat = 1'b0;

   always #5 clk = ~clk;

   rr_mult_sel #(
      .RADIX (RADIX),
      .P     (P),
      .DELTA (DLT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pp        (pp),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .z         (z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
`ifdef RR_MULT_SEL_SAT_FLAG_EN
      ,
      .sat_err   (sat_err)
`endif
   );

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reduce to a 14-bit two's-complement value.
   function automatic int wrap14(input int x);
      logic signed [13:0] t;
      t = x[13:0];
      return int'(t);
   endfunction

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q--;
      return q;
   endfunction

   function automatic int ppv_of(input logic [PW-1:0] vec);
      int s;
      s = 0;
      for (int i = 0; i < P; i++) begin
         int d;
         d = int'(vec[D*i +: D]);
         if (d >= 4) d -= 8;
         s += d * (RADIX ** i);
      end
      return s;
   endfunction

   // Expected digit stream for the operation in op_pp.
   task automatic build_model(input int n);
      int w, v, zr, steps, pv;
      w = 0;
      exp_q.delete();
      if (n > 1) exp_sat = 1'b0;
      steps = n + ((n < DLT) ? n : DLT);
      for (int k = 0; k < steps; k++) begin
         pv = (k < n) ? ppv_of(op_pp[k]) : 0;
         v  = wrap14(RADIX * w + pv);
         if (k < DLT && k < n) begin
            w = v;
         end else begin
            zr = floor_div(v + U / 2, U);
            if (zr > RADIX - 1) begin
               zr = RADIX - 1;
               exp_sat = 1'b1;
            end else if (zr < -(RADIX - 1)) begin
               zr = -(RADIX - 1);
               exp_sat = 1'b1;
            end
            exp_q.push_back(zr);
            w = wrap14(v - zr * U);
         end
      end
   endtask

   // mode 0: full rate; mode 1: random valid/ready; mode 2: 5-cycle out_ready stall in RUN.
   task automatic run_op(input int n, input int mode);
      int   sent, got, cyc, stall, exp_rdy;
      bit   stall_done, hold, prev_stuck;
      logic [D-1:0] prev_z;
      sent = 0; got = 0; cyc = 0; stall = 0;
      stall_done = 1'b0; hold = 1'b0; prev_stuck = 1'b0; prev_z = '0;
      build_model(n);
      while (got < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (mode == 2) begin
            if (!stall_done && stall == 0 && sent >= DLT + 1) stall = 5;
            if (stall > 0) begin
               out_ready = 1'b0;
               stall--;
               if (stall == 0) stall_done = 1'b1;
            end else begin
               out_ready = 1'b1;
            end
         end else if (mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
         if (!hold) begin
            if (sent < n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
               in_valid = 1'b1;
               pp       = op_pp[sent];
               in_last  = (sent == n - 1);
            end else begin
               in_valid = 1'b0;
               pp       = PW'($urandom);
               in_last  = 1'($urandom_range(0, 1));
            end
         end
         #1;
         if (prev_stuck) begin
            check("hold_valid", out_valid, 1);
            check("hold_z", z, prev_z);
         end
         if (sent == n) exp_rdy = 0;
         else if (sent < DLT) exp_rdy = 1;
         else exp_rdy = (!out_valid || out_ready) ? 1 : 0;
         check("in_ready", in_ready, exp_rdy);
         if (out_valid && out_ready) begin
            check("z", $signed(z), exp_q[got]);
            got++;
         end
         prev_stuck = out_valid && !out_ready;
         prev_z     = z;
         hold       = in_valid && !in_ready;
         if (in_valid && in_ready) sent++;
      end
      check("digit_count", got, n);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && busy; c++) begin
         @(negedge clk);
         #1;
         check("no_extra_digit", out_valid, 0);
      end
      check("busy_end", busy, 0);
      check("w_idle", dut.w_q, 0);
`ifdef RR_MULT_SEL_SAT_FLAG_EN
      check("sat_err", sat_err, exp_sat);
`endif
   endtask

   initial begin
      rst       = 1'b1;
      pp        = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_z", z, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);

      // Zero stream
      op_pp.delete();
      repeat (4) op_pp.push_back('0);
      run_op(4, 0);

      // Flush drain: PPV 1, 0, 0
      op_pp.delete();
      op_pp.push_back(9'b000_000_001);
      op_pp.push_back('0);
      op_pp.push_back('0);
      run_op(3, 0);

      // Negative digit: PPV -48 after two zero inputs
      op_pp.delete();
      op_pp.push_back('0);
      op_pp.push_back('0);
      op_pp.push_back(9'b101_000_000);
      run_op(3, 0);

      // Saturation: PPV 63 after two zero inputs
      op_pp.delete();
      op_pp.push_back('0);
      op_pp.push_back('0);
      op_pp.push_back(9'b011_011_011);
      run_op(3, 0);

      // Back-pressure mid-RUN
      op_pp.delete();
      for (int i = 0; i < 8; i++) op_pp.push_back(PW'($urandom));
      run_op(8, 2);

      // Reset during FLUSH with a digit pending
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         pp       = (k == 0) ? 9'b000_000_001 : '0;
         in_last  = (k == 2);
         #1;
         check("rstflush_in_ready", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      check("rstflush_busy", busy, 1);
      check("rstflush_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_in_ready", in_ready, 0);
      @(negedge clk);
      rst       = 1'b0;
      exp_sat   = 1'b0;
      out_ready = 1'b1;
      #1;
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_w", dut.w_q, 0);
      check("post_rst_in_ready", in_ready, 1);

      // Randomized operations
      for (int op = 0; op < 30; op++) begin
         int n;
         n = $urandom_range(1, 10);
         op_pp.delete();
         for (int i = 0; i < n; i++) op_pp.push_back(PW'($urandom));
         run_op(n, (op % 5 == 0) ? 0 : 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
